// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: the load/blank controls from the
// processor side and the registered segment/anode drive to the board.
interface seg7_scan_driver_if;
  logic [15:0] data_in;
  logic        data_valid;
  logic        blank;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  // data_valid is a one-cycle strobe with no ready: every strobe is accepted,
  // and data_in is sampled on the strobe cycle. A later strobe before the
  // frame boundary simply replaces the earlier word.
  modport master (
    output data_in,
    output data_valid,
    output blank,
    input  seg_n,
    input  an_n,
    input  frame_done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  blank,
    output seg_n,
    output an_n,
    output frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit hex 7-segment driver (common anode, active-low outputs).
// Words are double-buffered and committed only at frame boundaries.
// Optional macro SEG7_LZ_SUPPRESS_EN enables leading-zero suppression.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt;
  logic [1:0]    dig;
  logic [15:0]   shown;
  logic [15:0]   pending;
  logic          pend_v;

  logic          tick;
  logic          boundary;
  logic [3:0]    nib;
  logic [3:0]    dark;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (pcnt == PCNT_MAX);
    boundary = tick && (dig == 2'd3);
    nib      = shown[{dig, 2'b00} +: 4];
    seg_d    = hex7(nib);

`ifdef SEG7_LZ_SUPPRESS_EN
    // A digit goes dark only when it and every digit to its left are zero.
    dark[3] = (shown[15:12] == 4'h0);
    dark[2] = (shown[15:8]  == 8'h00);
    dark[1] = (shown[15:4]  == 12'h000);
    dark[0] = 1'b0;
`else
    dark    = 4'b0000;
`endif

    an_d = 4'b1111;
    if (!bus.blank && !dark[dig]) begin
      an_d = ~(4'b0001 << dig);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt           <= '0;
      dig            <= 2'd0;
      shown          <= 16'h0000;
      pending        <= 16'h0000;
      pend_v         <= 1'b0;
      bus.seg_n      <= 7'h7F;
      bus.an_n       <= 4'hF;
      bus.frame_done <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        dig <= dig + 2'd1;
      end

      if (boundary && pend_v) begin
        shown <= pending;
      end

      // A strobe on the boundary cycle always lands in pending and keeps
      // pend_v set, so it commits one frame later rather than this one.
      if (bus.data_valid) begin
        pending <= bus.data_in;
        pend_v  <= 1'b1;
      end else if (boundary) begin
        pend_v  <= 1'b0;
      end

      bus.frame_done <= boundary;
      bus.seg_n      <= seg_d;
      bus.an_n       <= an_d;
    end
  end

endmodule
